// File: rtl/secded_pkg.sv
// Shared constants, FSM states and result layout for the SECDED decoder engine.
package secded_pkg;

   localparam int unsigned NUM_WORDS = 15;
   localparam int unsigned IN_BASE   = 30;
   localparam int unsigned OUT_BASE  = 0;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned WORD_W    = 16;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned DMEM_D    = 256;
   localparam int unsigned ROM_AW    = 10;
   localparam int unsigned ROM_DW    = 9;
   localparam int unsigned ROM_D     = 1024;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_DEC,
      S_WR_LO,
      S_WR_HI,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      ST_NONE   = 2'b00,
      ST_SINGLE = 2'b01,
      ST_DOUBLE = 2'b10
   } status_t;

   typedef struct packed {
      status_t     status;
      logic [2:0]  rsvd;
      logic [10:0] data;
   } result_t;

endpackage

// File: rtl/secded_if.sv
// Byte-wide data memory bus: asynchronous read, synchronous write.
interface secded_if;
   import secded_pkg::*;

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              we;

   modport master (output addr, output wdata, output we, input rdata);
   modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/secded_decode.sv
// Combinational SECDED decode of one 16-bit codeword into a status + 11-bit data result.
module secded_decode
   import secded_pkg::*;
(
   input  logic [WORD_W-1:0] code,
   output result_t           result_c
);

   logic [3:0]        syn;
   logic              par;
   logic [WORD_W-1:0] fixed;

   always_comb begin
      syn   = '0;
      par   = ^code;
      fixed = code;
      result_c = '0;
      for (int n = 1; n < 16; n++) begin
         if (code[n]) syn = syn ^ 4'(n);
      end
      // Odd overall parity means one bit flipped; syndrome 0 points at p0.
      if (par) fixed[syn] = ~fixed[syn];
      result_c.data = {fixed[15:9], fixed[7:5], fixed[3]};
      if (par)              result_c.status = ST_SINGLE;
      else if (syn != 4'd0) result_c.status = ST_DOUBLE;
      else                  result_c.status = ST_NONE;
   end

endmodule

// File: rtl/secded_mem.sv
// Data memory (256x8, async read) and instruction ROM (1024x9) used by the engine.
module secded_dmem
   import secded_pkg::*;
(
   input logic     clk,
   secded_if.slave bus
);

   logic [DATA_W-1:0] core [DMEM_D];

   always_ff @(posedge clk) begin
      if (bus.we) core[bus.addr] <= bus.wdata;
   end

   assign bus.rdata = core[bus.addr];

endmodule

module secded_irom
   import secded_pkg::*;
(
   input  logic              clk,
   input  logic              load_en,
   input  logic [ROM_AW-1:0] load_addr,
   input  logic [ROM_DW-1:0] load_data,
   input  logic [ROM_AW-1:0] addr,
   output logic [ROM_DW-1:0] data_c
);

   logic [ROM_DW-1:0] core [ROM_D];

   // Programming port; normally the image is loaded externally.
   always_ff @(posedge clk) begin
      if (load_en) core[load_addr] <= load_data;
   end

   assign data_c = core[addr];

endmodule

// File: rtl/secded_top_level.sv
// SECDED decoder engine: walks NUM_WORDS codewords in dm1, writes decoded results back, then raises done.
module secded_top_level
   import secded_pkg::*;
(
   input  logic clk,
   input  logic reset,
   output logic done
);

   localparam int unsigned LAST_IDX = NUM_WORDS - 1;

   secded_if bus ();

   state_t              state;
   state_t              state_next;
   logic [IDX_W-1:0]    idx;
   logic [DATA_W-1:0]   lo_q;
   logic [WORD_W-1:0]   code_q;
   result_t             res_q;
   result_t             dec_c;
   logic [ADDR_W-1:0]   word_off;
   logic [ROM_DW-1:0]   instr_unused;

   secded_dmem dm1 (
      .clk (clk),
      .bus (bus)
   );

   secded_irom ir_inst (
      .clk       (clk),
      .load_en   (1'b0),
      .load_addr ('0),
      .load_data ('0),
      .addr      (ROM_AW'({idx, state})),
      .data_c    (instr_unused)
   );

   secded_decode u_decode (
      .code     (code_q),
      .result_c (dec_c)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  state_next = S_RD_LO;
         S_RD_LO: state_next = S_RD_HI;
         S_RD_HI: state_next = S_DEC;
         S_DEC:   state_next = S_WR_LO;
         S_WR_LO: state_next = S_WR_HI;
         S_WR_HI: state_next = (idx == IDX_W'(LAST_IDX)) ? S_DONE : S_RD_LO;
         S_DONE:  state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   assign word_off = ADDR_W'({idx, 1'b0});

   // Memory bus is a pure function of state and word index.
   always_comb begin
      bus.addr  = '0;
      bus.wdata = '0;
      bus.we    = 1'b0;
      case (state)
         S_RD_LO: bus.addr = ADDR_W'(IN_BASE) + word_off;
         S_RD_HI: bus.addr = ADDR_W'(IN_BASE) + word_off + ADDR_W'(1);
         S_WR_LO: begin
            bus.addr  = ADDR_W'(OUT_BASE) + word_off;
            bus.wdata = res_q[7:0];
            bus.we    = 1'b1;
         end
         S_WR_HI: begin
            bus.addr  = ADDR_W'(OUT_BASE) + word_off + ADDR_W'(1);
            bus.wdata = res_q[15:8];
            bus.we    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         idx  <= '0;
         done <= 1'b0;
      end else begin
         done <= (state_next == S_DONE);
         if (state == S_WR_HI) idx <= idx + IDX_W'(1);
      end
   end

   // Byte assembly and result staging need no reset; every run refills them before use.
   always_ff @(posedge clk) begin
      case (state)
         S_RD_LO: lo_q   <= bus.rdata;
         S_RD_HI: code_q <= {bus.rdata, lo_q};
         S_DEC:   res_q  <= dec_c;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_secded_top_level.sv
// Directed bench for secded_top_level: full runs, done timing, DONE write lockout and mid-run reset.
module tb_secded_top_level;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic done;

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0]  shadow [256];
   logic [15:0] in_w   [15];
   logic [15:0] exp_w  [15];

   logic [15:0] dir_in  [6] = '{16'h0000, 16'hFFFF, 16'h0008, 16'h0001, 16'h7FFF, 16'h0018};
   logic [15:0] dir_exp [6] = '{16'h0000, 16'h07FF, 16'h4000, 16'h4000, 16'h47FF, 16'h8001};

   always #5 clk = ~clk;

   secded_top_level dut (
      .clk   (clk),
      .reset (reset),
      .done  (done)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Parity-group formulation of the decoder, independent of the RTL's syndrome accumulation.
   function automatic logic [15:0] ref_decode(input logic [15:0] c);
      logic [3:0]  s;
      logic        p;
      logic [15:0] f;
      logic [10:0] d;
      int          k;
      s = '0;
      for (int b = 0; b < 4; b++)
         for (int n = 1; n < 16; n++)
            if (((n >> b) & 1) == 1) s[b] = s[b] ^ c[n];
      p = ^c;
      f = c;
      if (p) f[s] = ~f[s];
      d = '0;
      k = 0;
      for (int n = 1; n < 16; n++) begin
         if ((n & (n - 1)) != 0) begin
            d[k] = f[n];
            k++;
         end
      end
      if (p)              return {5'b01000, d};
      else if (s != 4'd0) return {5'b10000, d};
      else                return {5'b00000, d};
   endfunction

   function automatic logic [15:0] out_word(input int i);
      return {dut.dm1.core[2*i+1], dut.dm1.core[2*i]};
   endfunction

   task automatic load_inputs();
      for (int i = 0; i < 15; i++) begin
         shadow[30+2*i]   = in_w[i][7:0];
         shadow[30+2*i+1] = in_w[i][15:8];
         dut.dm1.core[30+2*i]   = in_w[i][7:0];
         dut.dm1.core[30+2*i+1] = in_w[i][15:8];
      end
   endtask

   task automatic check_run(input string tag);
      for (int i = 0; i < 15; i++)
         check($sformatf("%s_w%0d", tag, i), out_word(i), exp_w[i]);
      for (int b = 30; b < 256; b++)
         check($sformatf("%s_keep_b%0d", tag, b), {8'h00, dut.dm1.core[b]}, {8'h00, shadow[b]});
   endtask

   task automatic run_to_done(input string tag);
      @(negedge clk) reset = 1'b1;
      repeat (75) @(posedge clk);
      #1 check({tag, "_done_early"}, {15'd0, done}, 16'd0);
      @(posedge clk);
      #1 check({tag, "_done_rise"}, {15'd0, done}, 16'd1);
   endtask

   initial begin
      for (int b = 0; b < 256; b++) begin
         shadow[b] = 8'($urandom);
         dut.dm1.core[b] = shadow[b];
      end
      for (int i = 0; i < 6; i++) begin
         in_w[i]  = dir_in[i];
         exp_w[i] = dir_exp[i];
      end
      for (int i = 6; i < 15; i++) begin
         in_w[i]  = 16'($urandom);
         exp_w[i] = ref_decode(in_w[i]);
      end
      load_inputs();

      repeat (3) @(posedge clk);
      #1 check("reset_done", {15'd0, done}, 16'd0);

      // Run 1: directed patterns followed by random words.
      run_to_done("run1");
      check_run("run1");

      // Once in DONE, the output region must not be written again.
      @(negedge clk);
      for (int b = 0; b < 30; b++) dut.dm1.core[b] = 8'hA5;
      repeat (10) @(posedge clk);
      #1 check("done_hold", {15'd0, done}, 16'd1);
      for (int i = 0; i < 15; i++)
         check($sformatf("done_nowr_w%0d", i), out_word(i), 16'hA5A5);

      // Run 2: reset during word 7, then restart with a changed word 0.
      @(negedge clk) reset = 1'b0;
      in_w[0]  = 16'hFFFF;
      exp_w[0] = 16'h07FF;
      for (int i = 1; i < 15; i++) begin
         in_w[i]  = 16'($urandom);
         exp_w[i] = ref_decode(in_w[i]);
      end
      load_inputs();
      for (int b = 0; b < 30; b++) dut.dm1.core[b] = 8'h5A;
      @(posedge clk);
      #1 check("rst_from_done", {15'd0, done}, 16'd0);

      @(negedge clk) reset = 1'b1;
      repeat (38) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1 check("mid_rst_done", {15'd0, done}, 16'd0);
      for (int i = 0; i < 7; i++)
         check($sformatf("mid_kept_w%0d", i), out_word(i), exp_w[i]);
      check("mid_w7_unwritten", out_word(7), 16'h5A5A);

      in_w[0]  = 16'h0008;
      exp_w[0] = 16'h4000;
      load_inputs();
      repeat (2) @(posedge clk);
      #1 check("mid_rst_hold", {15'd0, done}, 16'd0);

      run_to_done("run2");
      check_run("run2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
